// File: rtl/sata_din_ppfifo_writer.sv
// Feeds a 32-bit valid/ready word stream into the ping-pong FIFO write port:
// claims a free channel, fills it until full, burst end or idle timeout, then commits it.
module sata_din_ppfifo_writer #(
  parameter int FLUSH_TIMEOUT = 64,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] user_din,
  output logic                  user_din_stb,
  input  logic [1:0]            user_din_ready,
  output logic [1:0]            user_din_activate,
  input  logic [23:0]           user_din_size,
  output logic                  busy,
  output logic [31:0]           words_total,
  output logic                  timeout_flush
);

  localparam logic [15:0] TIMEOUT = 16'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  activate_nx;
  logic [23:0] size_q, size_nx;
  logic [23:0] count, count_nx;
  logic [15:0] idle_tmr, idle_tmr_nx;
  logic        last_ch, last_ch_nx;
  logic [31:0] total_nx;
  logic        tflush_nx;
  logic        pick_ch;

  assign s_ready      = (state == WRITE) && (count < size_q);
  assign user_din     = s_data;
  assign user_din_stb = s_valid && s_ready;
  assign busy         = (state != IDLE);

  // With both channels free, alternate; last_ch resets to 1 so channel 0 goes first.
  always_comb begin
    case (user_din_ready)
      2'b11:   pick_ch = ~last_ch;
      2'b10:   pick_ch = 1'b1;
      default: pick_ch = 1'b0;
    endcase
  end

  always_comb begin
    state_nx    = state;
    activate_nx = user_din_activate;
    size_nx     = size_q;
    count_nx    = count;
    idle_tmr_nx = idle_tmr;
    last_ch_nx  = last_ch;
    total_nx    = words_total;
    tflush_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (en && (user_din_ready != 2'b00)) begin
          activate_nx = pick_ch ? 2'b10 : 2'b01;
          last_ch_nx  = pick_ch;
          size_nx     = user_din_size;
          count_nx    = 24'd0;
          idle_tmr_nx = 16'd0;
          state_nx    = WRITE;
        end
      end
      WRITE: begin
        if (size_q == 24'd0) begin
          activate_nx = 2'b00;
          state_nx    = RELEASE;
        end else if (user_din_stb) begin
          // A strobe clears the timer, so full/last always wins over timeout.
          count_nx    = count + 24'd1;
          total_nx    = words_total + 32'd1;
          idle_tmr_nx = 16'd0;
          if ((count + 24'd1 == size_q) || s_last) begin
            activate_nx = 2'b00;
            state_nx    = RELEASE;
          end
        end else if (count != 24'd0) begin
          idle_tmr_nx = idle_tmr + 16'd1;
          if (idle_tmr + 16'd1 == TIMEOUT) begin
            activate_nx = 2'b00;
            tflush_nx   = 1'b1;
            state_nx    = RELEASE;
          end
        end
      end
      RELEASE: state_nx = IDLE;
      default: begin
        activate_nx = 2'b00;
        state_nx    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      user_din_activate <= 2'b00;
      size_q            <= 24'd0;
      count             <= 24'd0;
      idle_tmr          <= 16'd0;
      last_ch           <= 1'b1;
      words_total       <= 32'd0;
      timeout_flush     <= 1'b0;
    end else begin
      state             <= state_nx;
      user_din_activate <= activate_nx;
      size_q            <= size_nx;
      count             <= count_nx;
      idle_tmr          <= idle_tmr_nx;
      last_ch           <= last_ch_nx;
      words_total       <= total_nx;
      timeout_flush     <= tflush_nx;
    end
  end

endmodule
